// File: rtl/spi_cfg_slave.sv
// rtl/spi_cfg_slave.sv - oversampled mode-0 SPI slave feeding an 8-bit configuration register bank
module spi_cfg_slave #(
    parameter int NUM_REGS    = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  USER_CLOCK,
    input  logic                  EXT_RESET_N,
    input  logic                  SPI_SS_N,
    input  logic                  SPI_SCLK,
    input  logic                  SPI_MOSI,
    output logic                  SPI_MISO,
    output logic                  SPI_MISO_OE,
    output logic [NUM_REGS*8-1:0] CFG_REGS,
    output logic                  WR_STROBE,
    output logic [6:0]            WR_ADDR,
    output logic [7:0]            WR_DATA,
    output logic                  FRAME_ERR
);

    localparam int         AW         = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [7:0] NUM_REGS_L = 8'(NUM_REGS);

    typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, ss_sync;
    logic                   sclk_d;
    logic                   sclk_s, mosi_s, ss_s, rise, fall;

    state_t     state;
    logic [3:0] bit_cnt;
    logic [6:0] rx_shift;
    logic [7:0] tx_shift;
    logic       rw_q, in_range_q;
    logic [6:0] addr_q;
    logic [7:0] regs [NUM_REGS];

    logic [6:0] cmd_addr;
    logic       cmd_in_range;
    logic [7:0] frame_data;

    always_ff @(posedge USER_CLOCK or negedge EXT_RESET_N) begin
        if (!EXT_RESET_N) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            ss_sync   <= '1;
            sclk_d    <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SPI_SCLK};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], SPI_MOSI};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SPI_SS_N};
            sclk_d    <= sclk_s;
        end
    end

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];
    assign ss_s   = ss_sync[SYNC_STAGES-1];
    assign rise   = sclk_s & ~sclk_d;
    assign fall   = ~sclk_s & sclk_d;

    // On the 8th rise the R/W bit sits in rx_shift[6] and the current MOSI is address bit 0.
    assign cmd_addr     = {rx_shift[5:0], mosi_s};
    assign cmd_in_range = {1'b0, cmd_addr} < NUM_REGS_L;
    assign frame_data   = {rx_shift, mosi_s};

    always_ff @(posedge USER_CLOCK or negedge EXT_RESET_N) begin
        if (!EXT_RESET_N) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            rw_q        <= 1'b0;
            in_range_q  <= 1'b0;
            addr_q      <= '0;
            SPI_MISO    <= 1'b0;
            SPI_MISO_OE <= 1'b0;
            WR_STROBE   <= 1'b0;
            WR_ADDR     <= '0;
            WR_DATA     <= '0;
            FRAME_ERR   <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            WR_STROBE <= 1'b0;
            FRAME_ERR <= 1'b0;
            case (state)
                IDLE: begin
                    if (!ss_s) begin
                        state       <= CMD;
                        bit_cnt     <= '0;
                        SPI_MISO_OE <= 1'b1;
                        SPI_MISO    <= 1'b0;
                    end
                end
                CMD: begin
                    if (rise) begin
                        rx_shift <= {rx_shift[5:0], mosi_s};
                        bit_cnt  <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            rw_q       <= rx_shift[6];
                            addr_q     <= cmd_addr;
                            in_range_q <= cmd_in_range;
                            tx_shift   <= (rx_shift[6] && cmd_in_range) ? regs[cmd_addr[AW-1:0]] : 8'h00;
                            FRAME_ERR  <= rx_shift[6] && !cmd_in_range;
                            state      <= DATA;
                        end
                    end else if (ss_s) begin
                        FRAME_ERR   <= 1'b1;
                        SPI_MISO    <= 1'b0;
                        SPI_MISO_OE <= 1'b0;
                        state       <= IDLE;
                    end
                end
                DATA: begin
                    // A rise coinciding with SS_N release still completes the frame.
                    if (rise) begin
                        rx_shift <= {rx_shift[5:0], mosi_s};
                        bit_cnt  <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd15) begin
                            state    <= DONE;
                            SPI_MISO <= 1'b0;
                            if (!rw_q) begin
                                if (in_range_q) begin
                                    regs[addr_q[AW-1:0]] <= frame_data;
                                    WR_STROBE            <= 1'b1;
                                    WR_ADDR              <= addr_q;
                                    WR_DATA              <= frame_data;
                                end else begin
                                    FRAME_ERR <= 1'b1;
                                end
                            end
                        end
                    end else if (ss_s) begin
                        FRAME_ERR   <= 1'b1;
                        SPI_MISO    <= 1'b0;
                        SPI_MISO_OE <= 1'b0;
                        state       <= IDLE;
                    end else if (fall) begin
                        SPI_MISO <= tx_shift[7];
                        tx_shift <= {tx_shift[6:0], 1'b0};
                    end
                end
                DONE: begin
                    SPI_MISO <= 1'b0;
                    if (ss_s) begin
                        SPI_MISO_OE <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign CFG_REGS[8*g +: 8] = regs[g];
    end

endmodule

// File: tb/tb_spi_cfg_slave.sv
// tb/tb_spi_cfg_slave.sv - directed frames against a register-bank model with per-cycle window checks
module tb_spi_cfg_slave;
    localparam int NR = 16;
    localparam int SS = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ss_n = 1'b1;
    logic         sclk = 1'b0;
    logic         mosi = 1'b0;
    logic         miso, miso_oe, wr_strobe, frame_err;
    logic [NR*8-1:0] cfg_regs;
    logic [6:0]   wr_addr;
    logic [7:0]   wr_data;

    spi_cfg_slave #(.NUM_REGS(NR), .SYNC_STAGES(SS)) dut (
        .USER_CLOCK (clk),
        .EXT_RESET_N(rst_n),
        .SPI_SS_N   (ss_n),
        .SPI_SCLK   (sclk),
        .SPI_MOSI   (mosi),
        .SPI_MISO   (miso),
        .SPI_MISO_OE(miso_oe),
        .CFG_REGS   (cfg_regs),
        .WR_STROBE  (wr_strobe),
        .WR_ADDR    (wr_addr),
        .WR_DATA    (wr_data),
        .FRAME_ERR  (frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Model: register image after the last finished frame, and the image if the current frame commits.
    logic [NR*8-1:0] exp_flat  = '0;
    logic [NR*8-1:0] pend_flat = '0;
    logic [6:0]      last_addr = '0;
    logic [7:0]      last_data = '0;

    int   n_strobe = 0;
    int   n_err = 0;
    int   quiet = 0;
    logic ss_prev = 1'b1;

    task automatic chk(input bit ok, input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    always @(negedge clk) begin
        if (ss_n !== ss_prev || !rst_n) quiet = 0;
        else if (quiet < 1000) quiet++;
        ss_prev = ss_n;
        if (rst_n) begin
            if (wr_strobe) n_strobe++;
            if (frame_err) n_err++;
        end
        if (quiet > SS + 3) begin
            chk(miso_oe == !ss_n, "miso_oe_level", 128'(miso_oe), 128'(!ss_n));
            if (ss_n) chk(miso == 1'b0, "miso_idle", 128'(miso), 128'(0));
        end
        chk(cfg_regs == exp_flat || cfg_regs == pend_flat, "cfg_window", cfg_regs, pend_flat);
    end

    task automatic run_frame(input logic [15:0] w, input int nbits, input bit do_rst, output logic [7:0] rx_byte);
        logic       rw;
        logic [6:0] a;
        bit         inr, commit, cmd_bad;
        int         e_err;
        logic [7:0] e_byte;
        rw      = w[15];
        a       = w[14:8];
        inr     = int'(a) < NR;
        commit  = !rw && inr && nbits >= 16 && !do_rst;
        pend_flat = exp_flat;
        if (commit) pend_flat[8*a +: 8] = w[7:0];
        e_byte  = (rw && inr) ? exp_flat[8*a +: 8] : 8'h00;
        e_err   = (nbits < 16 ? 1 : 0) + ((!inr && rw && nbits >= 8) ? 1 : 0)
                + ((!inr && !rw && nbits >= 16) ? 1 : 0);
        n_strobe = 0;
        n_err    = 0;
        rx_byte  = 8'h00;
        cmd_bad  = 1'b0;
        @(posedge clk); #2 ss_n = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        for (int i = 0; i < nbits; i++) begin
            mosi = (i < 16) ? w[15-i] : 1'b1;
            repeat (4) @(posedge clk);
            #2 sclk = 1'b1;
            if (i < 8) cmd_bad = cmd_bad | miso;
            else if (i < 16) rx_byte = {rx_byte[6:0], miso};
            repeat (4) @(posedge clk);
            #2 sclk = 1'b0;
        end
        if (do_rst) begin
            exp_flat  = '0;
            pend_flat = '0;
            last_addr = '0;
            last_data = '0;
            rst_n = 1'b0;
            ss_n  = 1'b1;
            mosi  = 1'b0;
            #1;
            chk(cfg_regs == '0, "async_rst_cfg", cfg_regs, 128'(0));
            chk(miso_oe == 1'b0, "async_rst_oe", 128'(miso_oe), 128'(0));
            chk(miso == 1'b0, "async_rst_miso", 128'(miso), 128'(0));
            chk(wr_strobe == 1'b0 && frame_err == 1'b0, "async_rst_pulses", 128'({wr_strobe, frame_err}), 128'(0));
            chk(wr_addr == 7'd0 && wr_data == 8'd0, "async_rst_wr", 128'({wr_addr, wr_data}), 128'(0));
            chk(n_strobe == 0, "rst_frame_strobe", 128'(n_strobe), 128'(0));
            repeat (3) @(posedge clk);
            #2 rst_n = 1'b1;
            repeat (16) @(posedge clk);
            #2;
            chk(n_strobe == 0, "rst_after_strobe", 128'(n_strobe), 128'(0));
            return;
        end
        repeat (4) @(posedge clk);
        #2 ss_n = 1'b1;
        repeat (16) @(posedge clk);
        #2;
        chk(n_strobe == (commit ? 1 : 0), "strobe_count", 128'(n_strobe), 128'(commit ? 1 : 0));
        chk(n_err == e_err, "frame_err_count", 128'(n_err), 128'(e_err));
        chk(cfg_regs == pend_flat, "cfg_regs", cfg_regs, pend_flat);
        if (commit) begin
            last_addr = a;
            last_data = w[7:0];
        end
        chk(wr_addr == last_addr, "wr_addr", 128'(wr_addr), 128'(last_addr));
        chk(wr_data == last_data, "wr_data", 128'(wr_data), 128'(last_data));
        chk(!cmd_bad, "miso_cmd_zero", 128'(cmd_bad), 128'(0));
        if (rw && nbits >= 16) chk(rx_byte == e_byte, "miso_byte", 128'(rx_byte), 128'(e_byte));
        exp_flat = pend_flat;
    endtask

    logic [7:0] rb;

    initial begin
        repeat (3) @(posedge clk);
        #2;
        chk(cfg_regs == '0, "reset_cfg", cfg_regs, 128'(0));
        chk(miso == 1'b0 && miso_oe == 1'b0, "reset_miso", 128'({miso, miso_oe}), 128'(0));
        chk(wr_strobe == 1'b0 && frame_err == 1'b0, "reset_pulses", 128'({wr_strobe, frame_err}), 128'(0));
        chk(wr_addr == 7'd0 && wr_data == 8'd0, "reset_wr", 128'({wr_addr, wr_data}), 128'(0));
        rst_n = 1'b1;
        repeat (4) @(posedge clk);

        run_frame(16'h03A5, 16, 1'b0, rb);
        chk(cfg_regs[31:24] == 8'hA5, "lit_reg3", 128'(cfg_regs[31:24]), 128'(8'hA5));
        chk(wr_addr == 7'h03 && wr_data == 8'hA5, "lit_wr", 128'({wr_addr, wr_data}), 128'(15'h03A5));
        run_frame(16'h8300, 16, 1'b0, rb);
        chk(rb == 8'hA5, "lit_read3", 128'(rb), 128'(8'hA5));
        run_frame(16'h205A, 16, 1'b0, rb);
        run_frame(16'hA000, 16, 1'b0, rb);
        chk(rb == 8'h00, "lit_read_oor", 128'(rb), 128'(0));
        run_frame(16'h05FF, 10, 1'b0, rb);
        chk(cfg_regs[47:40] == 8'h00, "lit_reg5_abort", 128'(cfg_regs[47:40]), 128'(0));
        run_frame(16'h0511, 16, 1'b0, rb);
        chk(cfg_regs[47:40] == 8'h11, "lit_reg5", 128'(cfg_regs[47:40]), 128'(8'h11));
        run_frame(16'h0742, 20, 1'b0, rb);
        chk(cfg_regs[63:56] == 8'h42, "lit_reg7", 128'(cfg_regs[63:56]), 128'(8'h42));
        run_frame(16'h8700, 16, 1'b0, rb);
        chk(rb == 8'h42, "lit_read7", 128'(rb), 128'(8'h42));
        run_frame(16'h0977, 16, 1'b0, rb);
        chk(cfg_regs[79:72] == 8'h77, "lit_reg9_pre", 128'(cfg_regs[79:72]), 128'(8'h77));
        run_frame(16'h09C3, 12, 1'b1, rb);
        chk(cfg_regs == '0, "lit_after_rst", cfg_regs, 128'(0));
        run_frame(16'h09C3, 16, 1'b0, rb);
        chk(cfg_regs[79:72] == 8'hC3, "lit_reg9", 128'(cfg_regs[79:72]), 128'(8'hC3));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/spi_cfg_slave.md
Name: spi_cfg_slave

Overview:
SPI slave that terminates one SPI_FLASH_SS line of the MicroBlaze SPI master. It deserialises 16-bit command frames into a bank of 8-bit configuration registers that drive the imager control logic, and returns register contents on MISO for read frames. All logic runs in the USER_CLOCK domain, and the SPI pins are oversampled.

Parameters:
NUM_REGS, 16, number of 8-bit configuration registers (1..128).
SYNC_STAGES, 2, synchroniser depth on SCLK/MOSI/SS_N (>=2).

Ports:
USER_CLOCK  in  1  system clock; must be >= 8x SCLK frequency.
EXT_RESET_N  in  1  asynchronous active-low reset.
SPI_SS_N  in  1  slave select from master, active-low.
SPI_SCLK  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
SPI_MOSI  in  1  serial data in, MSB first.
SPI_MISO  out  1  serial data out.
SPI_MISO_OE  out  1  MISO output enable (1 = drive, 0 = release).
CFG_REGS  out  NUM_REGS*8  flattened register bank; reg i is [8i+7:8i].
WR_STROBE  out  1  one-cycle pulse per committed register write.
WR_ADDR  out  7  address of the last committed write.
WR_DATA  out  8  data of the last committed write.
FRAME_ERR  out  1  one-cycle pulse on aborted frame or out-of-range address.

Behaviour:
- Reset (async assert, sync release): all registers 0x00; SPI_MISO=0; SPI_MISO_OE=0; WR_STROBE=0; WR_ADDR=0; WR_DATA=0; FRAME_ERR=0; FSM in IDLE.
- Input sync: SCLK, MOSI and SS_N each pass through SYNC_STAGES flops. Edge detect compares the last sync stage with one extra flop. "Rise" and "fall" are single-cycle internal pulses.
- Frame format: bit15 R/W (1 = read), bits14:8 address, bits7:0 data. MSB first. MOSI is sampled on the SCLK rise.
- FSM:
  - IDLE: on synced SS_N low -> CMD, bit counter = 0, SPI_MISO_OE=1, SPI_MISO=0.
  - CMD: shift MOSI on each rise. On the 8th rise, latch rw/addr and go to DATA. If read and addr<NUM_REGS, load the tx shifter with reg[addr]; otherwise load 0x00.
  - DATA: on each fall, SPI_MISO <= tx shifter MSB, then shift left. The first fall in DATA presents bit7 before the 9th rise. Shift MOSI on each rise. On the 16th rise, go to DONE.
  - Write commit (write frame, addr<NUM_REGS): in the cycle after the 16th-rise detection cycle, update reg[addr], pulse WR_STROBE and load WR_ADDR/WR_DATA. This is the same cycle CFG_REGS changes.
  - DONE: ignore further SCLK edges; no further writes and MISO stays 0. On SS_N high -> IDLE and SPI_MISO_OE=0.
- Latency: from the SCLK pin edge to the internal rise pulse is SYNC_STAGES+1 cycles. WR_STROBE follows one cycle later.
- Out-of-range addr (>=NUM_REGS):
  - Write: discarded; FRAME_ERR pulses at the would-be commit cycle.
  - Read: returns 0x00; FRAME_ERR pulses on the 8th rise +1 cycle.
- SS_N deasserted before the 16th rise (in CMD or DATA): abort. No register change, FRAME_ERR pulses for one cycle, return to IDLE, SPI_MISO_OE=0.
- SS_N high at the same cycle as the 16th rise is detected: the rise is processed first, so the frame commits and there is no FRAME_ERR.
- Back-to-back frames require SS_N high for >=1 SCLK period. A new frame starts only from IDLE.
- A read frame's data bits on MOSI are ignored.
- Reset mid-frame: immediate return to reset state; a partial frame never commits.

Test Plan:
- Write frame 0x03A5 (SS low, 16 SCLK at USER_CLOCK/8, SS high) -> WR_STROBE one pulse, WR_ADDR=0x03, WR_DATA=0xA5, CFG_REGS[31:24]=0xA5, all other regs 0x00, FRAME_ERR never high.
- Write 0x03A5, then read frame 0x8300 -> MISO bits 7..0 sampled on the master's rises read 0xA5; MISO=0 during CMD; SPI_MISO_OE high only while SS_N low.
- NUM_REGS=16, write frame 0x205A -> no WR_STROBE, CFG_REGS unchanged, one FRAME_ERR pulse. Read frame 0xA000 -> MISO returns 0x00 and FRAME_ERR pulses.
- Write frame 0x05FF aborted by SS high after 10 SCLK -> reg5 stays 0x00, one FRAME_ERR pulse. The next full frame 0x0511 -> reg5=0x11.
- 20 SCLK in one SS-low window with MOSI 0x0742 followed by 4 bits of 1 -> reg7=0x42, exactly one WR_STROBE.
- EXT_RESET_N pulsed low after 12 bits of 0x09C3 with reg9 preloaded to 0x77 -> all outputs return to reset values asynchronously, reg9=0x00, no WR_STROBE. A following full frame 0x09C3 -> reg9=0xC3.
